// File: rtl/pair_filter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// pair_filter_pkg : shared fp32 constants, FSM state type, accept test
// Rev 1.0
// ----------------------------------------------------------------------
package pair_filter_pkg;

  localparam int          FP32_W        = 32;
  localparam logic [31:0] FP32_INF      = 32'h7F80_0000;
  localparam logic [31:0] FP32_NEG_ZERO = 32'h8000_0000;
  localparam logic [15:0] CNT_MAX       = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Non-negative finite fp32 values order like their magnitude bits, so an
  // unsigned integer compare stands in for a float compare.
  function automatic logic r2_accept(input logic [FP32_W-1:0] r2,
                                     input logic [FP32_W-1:0] cut);
    return (r2 == FP32_NEG_ZERO) ||
           (!r2[31] && (r2[30:23] != 8'hFF) && (r2[30:0] < cut[30:0]));
  endfunction

endpackage
`default_nettype wire

// File: rtl/pair_filter_if.sv
`default_nettype none
// ----------------------------------------------------------------------
// pair_filter_if : config, pair input stream, output stream and status
// Rev 1.0
// ----------------------------------------------------------------------
interface pair_filter_if #(
  parameter int ID_W = 16
);
  import pair_filter_pkg::*;

  logic                  cfg_we;
  logic [FP32_W-1:0]     cfg_r2cut;
  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  logic [FP32_W-1:0]     in_r2;
  logic [3*FP32_W-1:0]   in_dr;
  logic [2*ID_W-1:0]     in_id;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [3*FP32_W-1:0]   out_dr;
  logic [FP32_W-1:0]     out_r2;
  logic [2*ID_W-1:0]     out_id;
  logic                  busy;
  logic                  done;
  logic [15:0]           n_acc;
  logic [15:0]           n_rej;

  modport master (
    output cfg_we, cfg_r2cut, start,
    output in_valid, in_r2, in_dr, in_id, in_last,
    input  in_ready,
    input  out_valid, out_dr, out_r2, out_id,
    output out_ready,
    input  busy, done, n_acc, n_rej
  );

  modport slave (
    input  cfg_we, cfg_r2cut, start,
    input  in_valid, in_r2, in_dr, in_id, in_last,
    output in_ready,
    output out_valid, out_dr, out_r2, out_id,
    input  out_ready,
    output busy, done, n_acc, n_rej
  );

endinterface
`default_nettype wire

// File: rtl/pair_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------
// pair_fifo : synchronous FIFO, head visible combinationally on dout_o
// Rev 1.0
// ----------------------------------------------------------------------
module pair_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push_i,
  input  wire logic [WIDTH-1:0] din_i,
  input  wire logic             pop_i,
  output logic      [WIDTH-1:0] dout_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule
`default_nettype wire

// File: rtl/pair_filter.sv
`default_nettype none
// ----------------------------------------------------------------------
// pair_filter : drops pairs beyond the squared cutoff, queues the rest
// Rev 1.0
// ----------------------------------------------------------------------
module pair_filter
  import pair_filter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = 16
) (
  input  wire logic    clk,
  input  wire logic    rst,
  pair_filter_if.slave bus
);

  localparam int DATA_W = 4*FP32_W + 2*ID_W;

  state_e              state_q;
  state_e              state_d;
  logic [FP32_W-1:0]   cut_q;
  logic [FP32_W-1:0]   cut_d;
  logic [15:0]         n_acc_q;
  logic [15:0]         n_acc_d;
  logic [15:0]         n_rej_q;
  logic [15:0]         n_rej_d;

  logic                fifo_empty;
  logic                fifo_full;
  logic [DATA_W-1:0]   fifo_dout;
  logic                in_rdy;
  logic                in_xfer;
  logic                pair_ok;
  logic                push;
  logic                pop;

  assign in_rdy  = (state_q == ST_RUN) && !fifo_full;
  assign in_xfer = bus.in_valid && in_rdy;
  assign pair_ok = r2_accept(bus.in_r2, cut_q);
  assign push    = in_xfer && pair_ok;
  assign pop     = !fifo_empty && bus.out_ready;

  pair_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   ({bus.in_dr, bus.in_r2, bus.in_id}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_RUN;
      ST_RUN:   if (in_xfer && bus.in_last) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = in_rdy;
    bus.busy     = (state_q != ST_IDLE);
    bus.done     = (state_q == ST_DONE);
  end

  // Cutoff is writable only while idle so a stream sees one threshold.
  always_comb begin
    cut_d   = cut_q;
    n_acc_d = n_acc_q;
    n_rej_d = n_rej_q;
    if (state_q == ST_IDLE) begin
      if (bus.cfg_we) cut_d = bus.cfg_r2cut;
      if (bus.start) begin
        n_acc_d = '0;
        n_rej_d = '0;
      end
    end else if (in_xfer) begin
      if (pair_ok) begin
        if (n_acc_q != CNT_MAX) n_acc_d = n_acc_q + 16'd1;
      end else begin
        if (n_rej_q != CNT_MAX) n_rej_d = n_rej_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cut_q   <= FP32_INF;
      n_acc_q <= '0;
      n_rej_q <= '0;
    end else begin
      cut_q   <= cut_d;
      n_acc_q <= n_acc_d;
      n_rej_q <= n_rej_d;
    end
  end

  assign bus.out_valid = !fifo_empty;
  assign bus.out_dr    = fifo_dout[DATA_W-1 -: 3*FP32_W];
  assign bus.out_r2    = fifo_dout[2*ID_W +: FP32_W];
  assign bus.out_id    = fifo_dout[2*ID_W-1:0];
  assign bus.n_acc     = n_acc_q;
  assign bus.n_rej     = n_rej_q;

endmodule
`default_nettype wire

// File: tb/tb_pair_filter.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_pair_filter : directed and random pair streams against a queue model
// Rev 1.0
// ----------------------------------------------------------------------
module tb_pair_filter;
  import pair_filter_pkg::*;

  localparam int DEPTH = 4;
  localparam int ID_W  = 16;
  localparam logic [31:0] F_0   = 32'h0000_0000;
  localparam logic [31:0] F_1   = 32'h3F80_0000;
  localparam logic [31:0] F_4   = 32'h4080_0000;
  localparam logic [31:0] F_9   = 32'h4110_0000;
  localparam logic [31:0] F_16  = 32'h4180_0000;
  localparam logic [31:0] F_25  = 32'h41C8_0000;
  localparam logic [31:0] F_100 = 32'h42C8_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pair_filter_if #(.ID_W(ID_W)) bus ();

  pair_filter #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 streaming, 2 draining, 3 finished.
  logic [159:0] mq[$];
  int           phase;
  logic [31:0]  mcut;
  logic [15:0]  macc;
  logic [15:0]  mrej;
  bit           last_in_x;
  bit           rand_ordy;
  int           n_done_obs;
  int           n_out_obs;

  function automatic bit m_accept(input logic [31:0] r2, input logic [31:0] cut);
    if (r2 == 32'h8000_0000) return 1'b1;
    if (r2[31]) return 1'b0;
    if (r2[30:23] == 8'hFF) return 1'b0;
    return r2[30:0] < cut[30:0];
  endfunction

  function automatic bit m_in_ready();
    return (phase == 1) && (mq.size() < DEPTH);
  endfunction

  task automatic m_reset();
    phase = 0;
    mcut  = 32'h7F80_0000;
    macc  = 16'd0;
    mrej  = 16'd0;
    mq.delete();
  endtask

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit in_x;
    bit out_x;
    int sz;
    if (rand_ordy) bus.out_ready = ($urandom_range(0, 3) != 0);
    check("in_ready",  bus.in_ready,  m_in_ready());
    check("out_valid", bus.out_valid, mq.size() > 0);
    check("busy",      bus.busy,      phase != 0);
    check("done",      bus.done,      phase == 3);
    check("n_acc",     bus.n_acc,     macc);
    check("n_rej",     bus.n_rej,     mrej);
    if (mq.size() > 0) check("out_data", {bus.out_dr, bus.out_r2, bus.out_id}, mq[0]);
    in_x  = bus.in_valid && m_in_ready();
    out_x = bus.out_ready && (mq.size() > 0);
    if (bus.out_valid && bus.out_ready) n_out_obs++;
    if (bus.done) n_done_obs++;
    last_in_x = in_x;
    sz = mq.size();
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else begin
      if (out_x) void'(mq.pop_front());
      case (phase)
        0: begin
          if (bus.cfg_we) mcut = bus.cfg_r2cut;
          if (bus.start) begin
            phase = 1;
            macc  = 16'd0;
            mrej  = 16'd0;
          end
        end
        1: if (in_x) begin
          if (m_accept(bus.in_r2, mcut)) begin
            mq.push_back({bus.in_dr, bus.in_r2, bus.in_id});
            if (macc != 16'hFFFF) macc = macc + 16'd1;
          end else begin
            if (mrej != 16'hFFFF) mrej = mrej + 16'd1;
          end
          if (bus.in_last) phase = 2;
        end
        2: if (sz == 0) phase = 3;
        default: phase = 0;
      endcase
    end
    #1;
  endtask

  task automatic send_pair(input logic [31:0] r2, input bit last);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_r2    = r2;
    bus.in_dr    = {$urandom, $urandom, $urandom};
    bus.in_id    = $urandom;
    bus.in_last  = last;
    do begin
      cycle();
      n++;
    end while (!last_in_x && n < 300);
    if (!last_in_x) begin
      total++;
      bad++;
      $error("FAIL send_timeout observed=%0d expected=transfer", n);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic start_stream(input bit wr, input logic [31:0] cut);
    if (wr) begin
      bus.cfg_we    = 1'b1;
      bus.cfg_r2cut = cut;
      cycle();
      bus.cfg_we    = 1'b0;
    end
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    while (phase != 0 && n < 500) begin
      cycle();
      n++;
    end
    if (phase != 0) begin
      total++;
      bad++;
      $error("FAIL idle_timeout observed=%0d expected=idle", phase);
    end
  endtask

  function automatic logic [31:0] rand_r2(input logic [31:0] cut);
    logic [31:0] v;
    logic [30:0] mag;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: begin
        mag = cut[30:0] + 31'($urandom_range(0, 6)) - 31'd3;
        v   = {1'b0, mag};
      end
      2: case ($urandom_range(0, 3))
        0:       v = 32'h8000_0000;
        1:       v = 32'h7FC0_0000;
        2:       v = 32'h7F80_0000;
        default: v = 32'h0000_0000;
      endcase
      default: v = {1'b0, 8'($urandom_range(100, 135)), 23'($urandom)};
    endcase
    return v;
  endfunction

  initial begin
    #500000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c;
    int len;
    int gap;
    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_r2cut = '0; bus.start = 1'b0;
    bus.in_valid = 1'b0; bus.in_r2 = '0; bus.in_dr = '0; bus.in_id = '0;
    bus.in_last = 1'b0; bus.out_ready = 1'b1;
    rand_ordy = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;
    cycle();

    // basic filter at cutoff 9.0
    n_done_obs = 0; n_out_obs = 0;
    start_stream(1'b1, F_9);
    send_pair(F_4, 1'b0);
    send_pair(F_9, 1'b0);
    send_pair(F_16, 1'b0);
    send_pair(F_0, 1'b1);
    wait_idle();
    check("s1_nacc", bus.n_acc, 16'd2);
    check("s1_nrej", bus.n_rej, 16'd2);
    check("s1_done_pulses", n_done_obs, 1);
    check("s1_outputs", n_out_obs, 2);

    // special encodings
    start_stream(1'b1, F_9);
    send_pair(32'h8000_0000, 1'b0);
    send_pair(32'h7FC0_0000, 1'b0);
    send_pair(32'h7F80_0000, 1'b0);
    send_pair(32'hBF80_0000, 1'b1);
    wait_idle();
    check("s2_nacc", bus.n_acc, 16'd1);
    check("s2_nrej", bus.n_rej, 16'd3);

    // backpressure: fill the FIFO, hold, then release
    n_out_obs = 0;
    start_stream(1'b1, F_9);
    bus.out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) send_pair(F_4, 1'b0);
    check("s3_ready_low", bus.in_ready, 1'b0);
    bus.in_valid = 1'b1; bus.in_r2 = F_1; bus.in_last = 1'b0;
    repeat (3) cycle();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    send_pair(F_4, 1'b0);
    send_pair(F_1, 1'b1);
    wait_idle();
    check("s3_delivered", n_out_obs, 6);

    // rejected last pair with empty FIFO
    n_done_obs = 0;
    start_stream(1'b1, F_9);
    send_pair(F_4, 1'b0);
    repeat (3) cycle();
    send_pair(F_25, 1'b1);
    check("s4_drain_done", bus.done, 1'b0);
    cycle();
    check("s4_done_high", bus.done, 1'b1);
    cycle();
    check("s4_done_low", bus.done, 1'b0);
    check("s4_done_pulses", n_done_obs, 1);

    // reset mid-stream with three queued entries
    start_stream(1'b1, F_9);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send_pair(F_4, 1'b0);
    bus.in_valid = 1'b1; bus.in_r2 = F_4;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("s5_out_valid", bus.out_valid, 1'b0);
    check("s5_busy", bus.busy, 1'b0);
    check("s5_nacc", bus.n_acc, 16'd0);
    start_stream(1'b0, F_0);
    send_pair(F_100, 1'b0);
    send_pair(32'h7F7F_FFFF, 1'b1);
    wait_idle();
    check("s5_inf_cut_nacc", bus.n_acc, 16'd2);

    // cutoff writes and start pulses during a stream are ignored
    start_stream(1'b1, F_9);
    bus.cfg_we = 1'b1; bus.cfg_r2cut = F_1;
    cycle();
    bus.cfg_we = 1'b0;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    send_pair(F_4, 1'b1);
    wait_idle();
    check("s6_locked_nacc", bus.n_acc, 16'd1);
    start_stream(1'b1, F_1);
    send_pair(F_4, 1'b1);
    wait_idle();
    check("s6_new_cut_nrej", bus.n_rej, 16'd1);
    check("s6_new_cut_nacc", bus.n_acc, 16'd0);

    // random streams with random gaps and downstream stalls
    for (int s = 0; s < 10; s++) begin
      c = {1'b0, 8'($urandom_range(110, 140)), 23'($urandom)};
      start_stream(1'b1, c);
      rand_ordy = 1'b1;
      len = $urandom_range(1, 24);
      for (int k = 0; k < len; k++) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          bus.start     = ($urandom_range(0, 7) == 0);
          bus.cfg_we    = ($urandom_range(0, 7) == 0);
          bus.cfg_r2cut = $urandom;
          cycle();
        end
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;
        send_pair(rand_r2(c), k == len - 1);
      end
      wait_idle();
      rand_ordy = 1'b0;
      bus.out_ready = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
